grayscale_quad_ci: RTL

- Multi-cycle custom-instruction block: converts four RGB565 pixels, two packed in each operand, into four 8-bit grayscale bytes packed in one 32-bit result.
- A small state machine time-shares one single-pixel grayscale datapath across the four pixels, so only one set of weight multipliers is instantiated.
- Sits on the CPU custom-instruction bus next to the other ISE blocks; the CPU stalls from start until done.

---
 rtl/grayscale_pkg.sv | 14 +
 rtl/rgb565_gray_pixel.sv | 26 ++
 rtl/grayscale_quad_ci.sv | 73 +++++++
 3 files changed

// File: rtl/grayscale_pkg.sv
// grayscale_pkg: shared types and constants for the RGB565 grayscale custom instruction
package grayscale_pkg;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    localparam logic [15:0] W_R = 16'd54;
    localparam logic [15:0] W_G = 16'd183;
    localparam logic [15:0] W_B = 16'd19;
    localparam int PIXELS_PER_OP = 4;
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;
endpackage

// File: rtl/rgb565_gray_pixel.sv
// rgb565_gray_pixel: combinational single-pixel RGB565 to 8-bit grayscale converter
module rgb565_gray_pixel
    import grayscale_pkg::*;
(
    input  logic [15:0] pixel,
    output logic [7:0]  gray
);
    logic [4:0]  r5;
    logic [5:0]  g6;
    logic [4:0]  b5;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    // replicate MSBs into the low bits so full-scale fields reach 255, then weight and drop the fraction
    always_comb begin
        r5   = pixel[R_MSB:R_LSB];
        g6   = pixel[G_MSB:G_LSB];
        b5   = pixel[B_MSB:B_LSB];
        r8   = {r5, r5[4:2]};
        g8   = {g6, g6[5:4]};
        b8   = {b5, b5[4:2]};
        sum  = W_R * {8'd0, r8} + W_G * {8'd0, g8} + W_B * {8'd0, b8};
        gray = sum[15:8];
    end
endmodule

// File: rtl/grayscale_quad_ci.sv
// grayscale_quad_ci: four-pixel RGB565 grayscale custom instruction sharing one pixel datapath
module grayscale_quad_ci
    import grayscale_pkg::*;
#(
    parameter logic [7:0] customInstructionId = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [7:0]  iseId,
    output logic        done,
    output logic [31:0] result
);
    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [63:0] buf_q, buf_d;
    logic [31:0] lanes_q, lanes_d;
    logic [15:0] pixel;
    logic [7:0]  gray;

    rgb565_gray_pixel u_pixel (
        .pixel (pixel),
        .gray  (gray)
    );

    // FSM next state, buffer latch, lane fill and bus-gated outputs
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        lanes_d = lanes_q;
        done    = 1'b0;
        result  = 32'd0;
        pixel   = buf_q[{idx_q, 4'b0000} +: 16];
        case (state_q)
            IDLE: begin
                if (start && iseId == customInstructionId) begin
                    buf_d   = {valueB, valueA};
                    idx_d   = 2'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                lanes_d[{idx_q, 3'b000} +: 8] = gray;
                idx_d   = idx_q + 2'd1;
                state_d = (idx_q == 2'(PIXELS_PER_OP - 1)) ? DONE : CONV;
            end
            DONE: begin
                done    = 1'b1;
                result  = lanes_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers with synchronous clear
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            buf_q   <= 64'd0;
            lanes_q <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            lanes_q <= lanes_d;
        end
    end
endmodule
